// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: redirect requests, RAS controls and the outputs pc_gen drives.
// master drives requests and observes pc; slave is the pc_gen side.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            if_ready;
  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            jmp_valid;
  logic [XLEN-1:0] jmp_target;
  logic            trap;
  logic            mret;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_addr;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] epc;
  logic            ras_empty;

  modport master (
    output if_ready, stall, br_taken, br_target, jmp_valid, jmp_target,
           trap, mret, ras_push, ras_push_addr, ras_pop,
    input  pc, pc_valid, epc, ras_empty
  );

  modport slave (
    input  if_ready, stall, br_taken, br_target, jmp_valid, jmp_target,
           trap, mret, ras_push, ras_push_addr, ras_pop,
    output pc, pc_valid, epc, ras_empty
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: one-cycle boot hold, then prioritised redirects
// (trap > mret > jump > branch > RAS return), stall/if_ready hold, else sequential increment.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic       clk_pc,
  input  logic       rst_pc,
  pc_gen_if.slave    bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  generate
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pc_gen: RAS_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_MRET,
    SRC_JMP,
    SRC_BR,
    SRC_RAS,
    SRC_HOLD,
    SRC_SEQ
  } src_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic            valid_q;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [CNT_W-1:0] cnt_q;

  src_t            src;
  logic [XLEN-1:0] pc_nxt;
  logic            ras_nonempty;
  logic            pop_sel;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;

  assign ras_nonempty = (cnt_q != '0);
  assign pop_sel      = (src == SRC_RAS);
  assign top_inc      = top_q + PTR_W'(1);
  assign top_dec      = top_q - PTR_W'(1);

  always_comb begin
    src = SRC_SEQ;
    if (bus.trap)                         src = SRC_TRAP;
    else if (bus.mret)                    src = SRC_MRET;
    else if (bus.jmp_valid)               src = SRC_JMP;
    else if (bus.br_taken)                src = SRC_BR;
    else if (bus.ras_pop && ras_nonempty) src = SRC_RAS;
    else if (bus.stall || !bus.if_ready)  src = SRC_HOLD;
  end

  always_comb begin
    pc_nxt = pc_q + XLEN'(INC);
    case (src)
      SRC_TRAP: pc_nxt = TRAP_VEC;
      SRC_MRET: pc_nxt = epc_q;
      SRC_JMP:  pc_nxt = bus.jmp_target;
      SRC_BR:   pc_nxt = bus.br_target;
      SRC_RAS:  pc_nxt = ras_q[top_q];
      SRC_HOLD: pc_nxt = pc_q;
      default:  pc_nxt = pc_q + XLEN'(INC);
    endcase
  end

  always_ff @(posedge clk_pc or posedge rst_pc) begin
    if (rst_pc) begin
      state   <= ST_BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      valid_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_BOOT: begin
          state   <= ST_RUN;
          pc_q    <= RESET_VEC;
          valid_q <= 1'b1;
        end
        ST_RUN: begin
          valid_q <= 1'b1;
          pc_q    <= pc_nxt;
          if (src == SRC_TRAP) begin
            epc_q <= pc_q;
          end
          // A push coinciding with a taken return replaces the entry just consumed.
          if (bus.ras_push && pop_sel) begin
            ras_q[top_q] <= bus.ras_push_addr;
          end else if (bus.ras_push) begin
            ras_q[top_inc] <= bus.ras_push_addr;
            top_q          <= top_inc;
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (pop_sel) begin
            top_q <= top_dec;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_BOOT;
          pc_q    <= RESET_VEC;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = valid_q;
  assign bus.epc       = epc_q;
  assign bus.ras_empty = (cnt_q == '0);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, stall/handshake, redirect priority, RAS, wrap and async reset.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) bus();

  pc_gen #(
    .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .INC(4), .RAS_DEPTH(4)
  ) dut (
    .clk_pc(clk),
    .rst_pc(rst),
    .bus(bus.slave)
  );

  task automatic idle_inputs();
    bus.if_ready      = 1'b1;
    bus.stall         = 1'b0;
    bus.br_taken      = 1'b0;
    bus.br_target     = '0;
    bus.jmp_valid     = 1'b0;
    bus.jmp_target    = '0;
    bus.trap          = 1'b0;
    bus.mret          = 1'b0;
    bus.ras_push      = 1'b0;
    bus.ras_push_addr = '0;
    bus.ras_pop       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [31:0] a);
    bus.jmp_valid  = 1'b1;
    bus.jmp_target = a;
    step();
    bus.jmp_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0 || bus.ras_empty !== 1'b1 || bus.epc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state pc=%h valid=%b empty=%b epc=%h want 0/0/1/0", bus.pc, bus.pc_valid, bus.ras_empty, bus.epc);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_hold pc=%h valid=%b want 0/0", bus.pc, bus.pc_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.pc !== 32'(i * 4) || bus.pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL first_fetch[%0d] pc=%h valid=%b want %h/1", i, bus.pc, bus.pc_valid, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h20, 32'h20, 32'h20, 32'h24};
    goto(32'h20);
    for (int i = 0; i < 4; i++) begin
      bus.stall    = (i < 2);
      bus.if_ready = (i != 2);
      step();
      checks++;
      if (bus.pc !== exp_pc[i] || bus.pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d] pc=%h valid=%b want %h/1", i, bus.pc, bus.pc_valid, exp_pc[i]);
      end
    end
    bus.stall     = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h80;
    step();
    checks++;
    if (bus.pc !== 32'h80) begin
      errors++;
      $display("FAIL branch_over_stall pc=%h want 00000080", bus.pc);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    goto(32'h40);
    bus.jmp_valid = 1'b1; bus.jmp_target = 32'h200;
    bus.br_taken  = 1'b1; bus.br_target  = 32'h300;
    bus.trap      = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h100 || bus.epc !== 32'h40) begin
      errors++;
      $display("FAIL trap_wins pc=%h epc=%h want 00000100/00000040", bus.pc, bus.epc);
    end
    idle_inputs();
    bus.mret = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h40) begin
      errors++;
      $display("FAIL mret pc=%h want 00000040", bus.pc);
    end
    idle_inputs();
    bus.jmp_valid = 1'b1; bus.jmp_target = 32'h200;
    bus.br_taken  = 1'b1; bus.br_target  = 32'h300;
    step();
    checks++;
    if (bus.pc !== 32'h200) begin
      errors++;
      $display("FAIL jmp_over_br pc=%h want 00000200", bus.pc);
    end
    idle_inputs();
    step();
    bus.trap = 1'b1;
    bus.mret = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h100 || bus.epc !== 32'h204) begin
      errors++;
      $display("FAIL trap_over_mret pc=%h epc=%h want 00000100/00000204", bus.pc, bus.epc);
    end
    idle_inputs();
  endtask

  task automatic test_ras();
    logic [31:0] exp_pop [4];
    exp_pop = '{32'h50, 32'h40, 32'h30, 32'h20};
    for (int i = 0; i < 5; i++) begin
      bus.ras_push      = 1'b1;
      bus.ras_push_addr = 32'((i + 1) * 16);
      step();
    end
    bus.ras_push = 1'b0;
    checks++;
    if (bus.ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL ras_nonempty empty=%b want 0", bus.ras_empty);
    end
    bus.ras_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.pc !== exp_pop[i]) begin
        errors++;
        $display("FAIL ras_pop[%0d] pc=%h want %h", i, bus.pc, exp_pop[i]);
      end
    end
    bus.ras_pop = 1'b0;
    checks++;
    if (bus.ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL ras_drained empty=%b want 1", bus.ras_empty);
    end
    goto(32'h60);
    bus.ras_pop = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h64) begin
      errors++;
      $display("FAIL pop_empty pc=%h want 00000064", bus.pc);
    end
    idle_inputs();
    // push and taken return together: return uses old top, top then replaced
    bus.ras_push = 1'b1; bus.ras_push_addr = 32'hA0; step();
    bus.ras_push_addr = 32'hB0; step();
    bus.ras_pop = 1'b1; bus.ras_push_addr = 32'hC0; step();
    checks++;
    if (bus.pc !== 32'hB0) begin
      errors++;
      $display("FAIL push_pop_pc pc=%h want 000000b0", bus.pc);
    end
    bus.ras_push = 1'b0; step();
    checks++;
    if (bus.pc !== 32'hC0) begin
      errors++;
      $display("FAIL push_pop_replaced pc=%h want 000000c0", bus.pc);
    end
    step();
    checks++;
    if (bus.pc !== 32'hA0 || bus.ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_bottom pc=%h empty=%b want 000000a0/1", bus.pc, bus.ras_empty);
    end
    idle_inputs();
    bus.ras_push = 1'b1; bus.ras_push_addr = 32'hD0; step();
    bus.ras_push = 1'b0;
    bus.ras_pop = 1'b1; bus.jmp_valid = 1'b1; bus.jmp_target = 32'h300;
    step();
    checks++;
    if (bus.pc !== 32'h300 || bus.ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL masked_pop pc=%h empty=%b want 00000300/0", bus.pc, bus.ras_empty);
    end
    bus.jmp_valid = 1'b0;
    step();
    checks++;
    if (bus.pc !== 32'hD0 || bus.ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL masked_pop_kept pc=%h empty=%b want 000000d0/1", bus.pc, bus.ras_empty);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFC);
    step();
    checks++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap pc=%h valid=%b want 00000000/1", bus.pc, bus.pc_valid);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    step();
    bus.trap = 1'b1;
    step();
    bus.trap = 1'b0;
    bus.ras_push = 1'b1; bus.ras_push_addr = 32'h5;
    bus.jmp_valid = 1'b1; bus.jmp_target = 32'h88;
    step();
    idle_inputs();
    checks++;
    if (bus.pc !== 32'h88 || bus.epc !== 32'h4 || bus.ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset pc=%h epc=%h empty=%b want 00000088/00000004/0", bus.pc, bus.epc, bus.ras_empty);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0 || bus.ras_empty !== 1'b1 || bus.epc !== 32'h0) begin
      errors++;
      $display("FAIL async_reset pc=%h valid=%b empty=%b epc=%h want 0/0/1/0", bus.pc, bus.pc_valid, bus.ras_empty, bus.epc);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.jmp_valid = 1'b1; bus.jmp_target = 32'h200;
    step();
    checks++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL boot_ignores_jmp pc=%h valid=%b want 00000000/1", bus.pc, bus.pc_valid);
    end
    step();
    checks++;
    if (bus.pc !== 32'h200) begin
      errors++;
      $display("FAIL jmp_after_boot pc=%h want 00000200", bus.pc);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_ras();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It is the successor to the single-register PC, with configurable width, reset and trap vectors, and increment. It adds:
- a one-cycle boot hold;
- stall and fetch handshake;
- prioritised branch/jump/trap/return redirects;
- an exception PC register;
- a small return-address stack (RAS).

It feeds the instruction-memory address and takes redirects from execute and the trap logic.

## Interface
- XLEN, 32, PC and address width
- RESET_VEC, 32'h0000_0000, PC value held from reset through the boot cycle
- TRAP_VEC, 32'h0000_0100, PC loaded on trap
- INC, 4, sequential increment
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk_pc  in  1  clock, rising edge
- rst_pc  in  1  asynchronous reset, active-high
- if_ready  in  1  fetch accepts the current pc this cycle
- stall  in  1  pipeline stall; hold pc
- br_taken  in  1  branch redirect
- br_target  in  XLEN  branch target
- jmp_valid  in  1  jump redirect
- jmp_target  in  XLEN  jump target
- trap  in  1  exception/interrupt; redirect to TRAP_VEC
- mret  in  1  return from trap; redirect to epc
- ras_push  in  1  call retired; push ras_push_addr
- ras_push_addr  in  XLEN  return address to push
- ras_pop  in  1  return instruction; redirect to RAS top
- pc  out  XLEN  current fetch address
- pc_valid  out  1  pc is a valid fetch request
- epc  out  XLEN  PC captured at the last trap
- ras_empty  out  1  RAS holds no entries

## Operation
- Reset (async, any time) forces these values:
  - pc=RESET_VEC, epc=0;
  - RAS count=0, top pointer=0, all entries 0;
  - state=BOOT, pc_valid=0, ras_empty=1.
- State BOOT:
  - pc held at RESET_VEC, pc_valid=0;
  - all request inputs ignored, RAS unchanged;
  - moves to RUN after one clock.
- State RUN: pc_valid=1. Next pc is chosen in strict priority, first match wins:
  1. trap: pc←TRAP_VEC, epc←pc.
  2. mret: pc←epc.
  3. jmp_valid: pc←jmp_target. Jumps win over branches when both are asserted.
  4. br_taken: pc←br_target.
  5. ras_pop with RAS non-empty: pc←RAS top, then pop.
  6. stall, or !if_ready: pc held.
  7. Otherwise: pc←pc+INC, truncated to XLEN. This wraps, so all-ones minus INC+1 goes to 0.
- Redirects (1–5) override stall and !if_ready.
- The RAS pop in 5 happens only when 5 is the selected source. A ras_pop masked by 1–4 is dropped and the RAS is untouched.
- RAS behaviour, all in RUN only:
  - push: entry[top+1]←ras_push_addr, top pointer increments, count saturates at RAS_DEPTH. Pushing when full overwrites the oldest entry, circularly.
  - pop on empty: ignored, and pc follows rules 6/7.
  - push and selected pop in the same cycle: the redirect uses the old top, then the top entry is overwritten by ras_push_addr. Pointer and count are unchanged.
  - push and masked pop in the same cycle: the push proceeds normally.
  - ras_empty = (count==0).
- epc changes only on a selected trap. A trap and mret together means the trap wins and epc←pc.

## Timing
- All state updates on the rising edge of clk_pc. Outputs are registered, with no combinational path from inputs to pc.
- Redirect latency: a request sampled at edge N is visible on pc after edge N.
- First valid fetch:
  - rst_pc deasserts; the first edge enters RUN with pc=RESET_VEC and pc_valid=1;
  - the second edge advances pc only if if_ready is high and there is no stall.
- Fetch handshake: the pc is consumed when pc_valid && if_ready. pc_valid never drops in RUN.
- Reset asserted mid-operation returns to BOOT immediately, asynchronously. Any in-flight redirect is lost.

## Test plan
- Reset, then if_ready=1 for four edges. Required:
  - pc=0 with pc_valid=0 during BOOT;
  - then pc=0, 4, 8, 12 with pc_valid=1.
- At pc=0x20 assert stall for 2 cycles, then if_ready=0 for 1 cycle. Required:
  - pc holds 0x20 for 3 cycles, then goes to 0x24;
  - br_taken with target 0x80 during the stall gives pc=0x80 on the next edge.
- At pc=0x40 assert jmp_valid (target 0x200), br_taken (target 0x300) and trap together. Required:
  - pc=0x100 and epc=0x40;
  - then mret gives pc=0x40.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4. Required:
  - pops return 0x50, 0x40, 0x30, 0x20;
  - ras_empty=1 after them;
  - a fifth pop at pc=0x60 gives pc=0x64.
- Set pc=0xFFFF_FFFC with if_ready=1. Required: pc wraps to 0x0.
- Assert rst_pc between clock edges while pc=0x88. Required:
  - pc=0, pc_valid=0, ras_empty=1, epc=0 immediately, before the next edge.
